presorter_stream: RTL and testbench

- Parametrised successor of the fixed 16-lane presorter.
- Sorts each input beat of NUM_ELEM packed elements into ascending order (lane 0 smallest) using a fully pipelined bitonic network.
- Adds a valid/ready handshake with backpressure, a key sub-field compare, and a last-beat sideband.
- Sits between the AXI read datapath and the leaf FIFO distributor of the merger tree.

---
 rtl/presorter_pkg.sv | 36 +++
 rtl/presort_cas_cell.sv | 35 +++
 rtl/presorter_stream.sv | 110 +++++++++++
 tb/tb_presorter_stream.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/presorter_pkg.sv
// Shared helpers for the streaming bitonic presorter: stage count and the
// mapping from a flat pipeline stage index to its (phase, step) pair.
package presorter_pkg;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic bit is_pow2(input int n);
        return (n >= 2) && ((n & (n - 1)) == 0);
    endfunction

    function automatic int num_stages(input int n);
        int l;
        l = clog2(n);
        return l * (l + 1) / 2;
    endfunction

    // Phase p owns stages [p(p-1)/2, p(p+1)/2); steps run p-1 down to 0.
    function automatic int stage_phase(input int t);
        int p;
        p = 1;
        while (p * (p + 1) / 2 <= t) p++;
        return p;
    endfunction

    function automatic int stage_step(input int t);
        int p;
        p = stage_phase(t);
        return p - 1 - (t - p * (p - 1) / 2);
    endfunction

endpackage

// File: rtl/presort_cas_cell.sv
// Registered compare-and-swap: lo/hi take the pair in the order given by dir
// (0 = ascending); only the top KEY_WIDTH bits take part in the compare.
module presort_cas_cell #(
    parameter int DATA_WIDTH = 32,
    parameter int KEY_WIDTH  = 32
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  en,
    input  logic                  dir,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] lo,
    output logic [DATA_WIDTH-1:0] hi
);

    logic [KEY_WIDTH-1:0] key_a, key_b;
    logic                 swap;

    assign key_a = a[DATA_WIDTH-1 -: KEY_WIDTH];
    assign key_b = b[DATA_WIDTH-1 -: KEY_WIDTH];
    // Strict compares: equal keys keep their lane positions.
    assign swap  = dir ? (key_b > key_a) : (key_a > key_b);

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            lo <= '0;
            hi <= '0;
        end else if (en) begin
            lo <= swap ? b : a;
            hi <= swap ? a : b;
        end
    end

endmodule

// File: rtl/presorter_stream.sv
// Streaming bitonic presorter: sorts NUM_ELEM lanes per beat, lane 0 smallest,
// with a global-stall valid/ready pipeline. PRESORTER_DESCEND_EN adds in_desc.
module presorter_stream
    import presorter_pkg::*;
#(
    parameter int NUM_ELEM   = 16,
    parameter int DATA_WIDTH = 32,
    parameter int KEY_WIDTH  = 32
) (
    input  logic                           aclk,
    input  logic                           areset,
    input  logic [NUM_ELEM*DATA_WIDTH-1:0] in_data,
    input  logic                           in_last,
    input  logic                           in_valid,
`ifdef PRESORTER_DESCEND_EN
    input  logic                           in_desc,
`endif
    output logic                           in_ready,
    output logic [NUM_ELEM*DATA_WIDTH-1:0] out_data,
    output logic                           out_last,
    output logic                           out_valid,
    input  logic                           out_ready
);

    localparam int L       = clog2(NUM_ELEM);
    localparam int STAGES  = num_stages(NUM_ELEM);
    localparam bit ELEM_OK = is_pow2(NUM_ELEM);
    localparam bit KEY_OK  = (KEY_WIDTH >= 1) && (KEY_WIDTH <= DATA_WIDTH);

    if (!ELEM_OK) begin : g_bad_num_elem
        $error("presorter_stream: NUM_ELEM must be a power of 2 and at least 2");
    end
    if (!KEY_OK) begin : g_bad_key_width
        $error("presorter_stream: KEY_WIDTH must be in 1..DATA_WIDTH");
    end

    logic adv;

    // Index t is the input of stage t; index STAGES is the output register.
    wire  [NUM_ELEM-1:0][DATA_WIDTH-1:0] dat_pipe [STAGES+1];
    logic [STAGES:1] vld_q, last_q;
    logic [STAGES:0] vld_pipe, last_pipe;

    assign vld_pipe  = {vld_q, in_valid};
    assign last_pipe = {last_q, in_last};
    assign dat_pipe[0] = in_data;

    assign out_valid = vld_pipe[STAGES];
    assign out_last  = last_pipe[STAGES];
    assign out_data  = dat_pipe[STAGES];
    assign adv       = out_ready | ~out_valid;
    assign in_ready  = adv;

`ifdef PRESORTER_DESCEND_EN
    logic [STAGES:1] desc_q;
    logic [STAGES:0] desc_pipe;
    assign desc_pipe = {desc_q, in_desc};

    always_ff @(posedge aclk or posedge areset) begin
        if (areset)   desc_q <= '0;
        else if (adv) desc_q <= desc_pipe[STAGES-1:0];
    end
`endif

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            vld_q  <= '0;
            last_q <= '0;
        end else if (adv) begin
            vld_q  <= vld_pipe[STAGES-1:0];
            last_q <= last_pipe[STAGES-1:0];
        end
    end

    for (genvar t = 0; t < STAGES; t++) begin : g_stage
        localparam int P = stage_phase(t);
        localparam int S = stage_step(t);
        for (genvar i = 0; i < NUM_ELEM; i++) begin : g_lane
            if (((i >> S) & 1) == 0) begin : g_cas
                localparam int J = i + (1 << S);
                logic dir;
                if (P == L) begin : g_final
`ifdef PRESORTER_DESCEND_EN
                    assign dir = desc_pipe[t];
`else
                    assign dir = 1'b0;
`endif
                end else begin : g_merge
                    // Sub-sequences of size 2^P alternate direction by bit P.
                    assign dir = (((i >> P) & 1) != 0);
                end

                presort_cas_cell #(
                    .DATA_WIDTH(DATA_WIDTH),
                    .KEY_WIDTH (KEY_WIDTH)
                ) u_cas (
                    .aclk  (aclk),
                    .areset(areset),
                    .en    (adv),
                    .dir   (dir),
                    .a     (dat_pipe[t][i]),
                    .b     (dat_pipe[t][J]),
                    .lo    (dat_pipe[t+1][i]),
                    .hi    (dat_pipe[t+1][J])
                );
            end
        end
    end

endmodule

// File: tb/tb_presorter_stream.sv
// Directed-vector and scoreboard bench for presorter_stream (16/8/2 lanes, narrow key).
module tb_presorter_stream;

    localparam int N  = 16;
    localparam int W  = 32;
    localparam int ST = 10;
    localparam int BW = N * W;

    logic aclk = 1'b0;
    logic areset;
    always #5 aclk = ~aclk;

    int errors = 0;
    int checks = 0;

    // Main DUT, default parameters
    logic [BW-1:0] in_data, out_data;
    logic in_last, in_valid, in_ready, out_last, out_valid, out_ready;
`ifdef PRESORTER_DESCEND_EN
    logic in_desc;
`endif

    presorter_stream u_dut (
        .aclk(aclk), .areset(areset),
        .in_data(in_data), .in_last(in_last), .in_valid(in_valid),
`ifdef PRESORTER_DESCEND_EN
        .in_desc(in_desc),
`endif
        .in_ready(in_ready),
        .out_data(out_data), .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready)
    );

    // Narrow key: only the top 8 bits compare
    logic [BW-1:0] k_in_data, k_out_data;
    logic k_in_valid, k_in_ready, k_out_last, k_out_valid;
    presorter_stream #(.NUM_ELEM(16), .DATA_WIDTH(32), .KEY_WIDTH(8)) u_key (
        .aclk(aclk), .areset(areset),
        .in_data(k_in_data), .in_last(1'b0), .in_valid(k_in_valid),
`ifdef PRESORTER_DESCEND_EN
        .in_desc(1'b0),
`endif
        .in_ready(k_in_ready),
        .out_data(k_out_data), .out_last(k_out_last), .out_valid(k_out_valid), .out_ready(1'b1)
    );

    logic [2*W-1:0] t_in_data, t_out_data;
    logic t_in_valid, t_in_ready, t_out_last, t_out_valid;
    presorter_stream #(.NUM_ELEM(2), .DATA_WIDTH(32), .KEY_WIDTH(32)) u_two (
        .aclk(aclk), .areset(areset),
        .in_data(t_in_data), .in_last(1'b1), .in_valid(t_in_valid),
`ifdef PRESORTER_DESCEND_EN
        .in_desc(1'b0),
`endif
        .in_ready(t_in_ready),
        .out_data(t_out_data), .out_last(t_out_last), .out_valid(t_out_valid), .out_ready(1'b1)
    );

    logic [8*W-1:0] e_in_data, e_out_data;
    logic e_in_valid, e_in_ready, e_out_last, e_out_valid;
    presorter_stream #(.NUM_ELEM(8), .DATA_WIDTH(32), .KEY_WIDTH(32)) u_eight (
        .aclk(aclk), .areset(areset),
        .in_data(e_in_data), .in_last(1'b1), .in_valid(e_in_valid),
`ifdef PRESORTER_DESCEND_EN
        .in_desc(1'b0),
`endif
        .in_ready(e_in_ready),
        .out_data(e_out_data), .out_last(e_out_last), .out_valid(e_out_valid), .out_ready(1'b1)
    );

    task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [BW-1:0] pack16(input int unsigned v [16]);
        logic [BW-1:0] r;
        for (int k = 0; k < 16; k++) r[k*W +: W] = v[k];
        return r;
    endfunction

    function automatic logic [BW-1:0] sort16(input logic [BW-1:0] d);
        logic [W-1:0] v [16];
        logic [W-1:0] tmp;
        logic [BW-1:0] r;
        for (int k = 0; k < 16; k++) v[k] = d[k*W +: W];
        for (int a = 0; a < 15; a++)
            for (int b = 0; b < 15 - a; b++)
                if (v[b] > v[b+1]) begin tmp = v[b]; v[b] = v[b+1]; v[b+1] = tmp; end
        for (int k = 0; k < 16; k++) r[k*W +: W] = v[k];
        return r;
    endfunction

    // One isolated beat into the main DUT: latency, data, last, single-cycle valid.
    task automatic send_one(input string name, input logic [BW-1:0] d, input logic l,
                            input logic [BW-1:0] exp);
        int lat;
        @(negedge aclk);
        in_data = d; in_last = l; in_valid = 1'b1;
        @(negedge aclk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin @(negedge aclk); lat++; end
        chk({name, "_lat"}, lat, ST);
        chk({name, "_data"}, out_data, exp);
        chk({name, "_last"}, out_last, l);
        @(negedge aclk);
        chk({name, "_vld_drop"}, out_valid, 1'b0);
    endtask

    function automatic logic small_valid(input int which);
        case (which)
            0:       return k_out_valid;
            1:       return t_out_valid;
            default: return e_out_valid;
        endcase
    endfunction

    function automatic logic [BW-1:0] small_data(input int which);
        case (which)
            0:       return k_out_data;
            1:       return {{(BW-2*W){1'b0}}, t_out_data};
            default: return {{(BW-8*W){1'b0}}, e_out_data};
        endcase
    endfunction

    task automatic run_small(input string name, input int which, input logic [BW-1:0] d,
                             input logic [BW-1:0] exp, input int exp_lat);
        int lat;
        @(negedge aclk);
        case (which)
            0:       begin k_in_data = d; k_in_valid = 1'b1; end
            1:       begin t_in_data = d[2*W-1:0]; t_in_valid = 1'b1; end
            default: begin e_in_data = d[8*W-1:0]; e_in_valid = 1'b1; end
        endcase
        @(negedge aclk);
        k_in_valid = 1'b0; t_in_valid = 1'b0; e_in_valid = 1'b0;
        lat = 1;
        while (!small_valid(which) && lat < 40) begin @(negedge aclk); lat++; end
        chk({name, "_lat"}, lat, exp_lat);
        chk({name, "_data"}, small_data(which), exp);
    endtask

    typedef struct packed {
        logic [BW-1:0] din;
        logic [BW-1:0] dexp;
        logic          last;
    } vec_t;

    vec_t vecs [4];
    int unsigned a [16];
    int unsigned e [16];

    logic [BW-1:0] exp_q [$];
    logic          exp_last_q [$];

    initial begin
        logic [BW-1:0] d, held_data, front;
        logic          held_last, stalled, seen;
        int            sent, cyc;

        areset = 1'b1;
        in_data = '0; in_last = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
`ifdef PRESORTER_DESCEND_EN
        in_desc = 1'b0;
`endif
        k_in_data = '0; k_in_valid = 1'b0;
        t_in_data = '0; t_in_valid = 1'b0;
        e_in_data = '0; e_in_valid = 1'b0;

        // Directed vectors, hand-computed
        a = '{15,14,13,12,11,10,9,8,7,6,5,4,3,2,1,0};
        e = '{0,1,2,3,4,5,6,7,8,9,10,11,12,13,14,15};
        vecs[0].din = pack16(a); vecs[0].dexp = pack16(e); vecs[0].last = 1'b1;
        vecs[1].din = pack16(e); vecs[1].dexp = pack16(e); vecs[1].last = 1'b0;
        a = '{3,1,3,0,2,2,1,0,3,3,0,1,2,0,1,2};
        e = '{0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3};
        vecs[2].din = pack16(a); vecs[2].dexp = pack16(e); vecs[2].last = 1'b1;
        a = '{32'hFFFFFFFF, 0, 32'h80000000, 32'h7FFFFFFF, 1, 32'hFFFFFFFE, 2, 32'h80000001,
              10, 20, 30, 40, 50, 60, 70, 32'h7FFFFFFE};
        e = '{0, 1, 2, 10, 20, 30, 40, 50, 60, 70, 32'h7FFFFFFE, 32'h7FFFFFFF,
              32'h80000000, 32'h80000001, 32'hFFFFFFFE, 32'hFFFFFFFF};
        vecs[3].din = pack16(a); vecs[3].dexp = pack16(e); vecs[3].last = 1'b0;

        #12;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_data", out_data, '0);
        chk("rst_out_last", out_last, 1'b0);
        @(negedge aclk);
        areset = 1'b0;

        for (int i = 0; i < 4; i++)
            send_one($sformatf("vec%0d", i), vecs[i].din, vecs[i].last, vecs[i].dexp);

        // Narrow key: non-key bits differ but keys are equal, so nothing moves
        for (int k = 0; k < 16; k++) d[k*W +: W] = 32'h5A000000 | k;
        run_small("key_eq_fwd", 0, d, d, ST);
        for (int k = 0; k < 16; k++) d[k*W +: W] = 32'h5A000000 | (15 - k);
        run_small("key_eq_rev", 0, d, d, ST);

        d = '0; d[W-1:0] = 32'd7; d[2*W-1:W] = 32'd3;
        front = '0; front[W-1:0] = 32'd3; front[2*W-1:W] = 32'd7;
        run_small("two_lane", 1, d, front, 1);

        d = '0; front = '0;
        for (int k = 0; k < 8; k++) begin
            d[k*W +: W] = 7 - k;
            front[k*W +: W] = k;
        end
        run_small("eight_lane", 2, d, front, 6);

`ifdef PRESORTER_DESCEND_EN
        in_desc = 1'b1;
        send_one("desc_on", vecs[1].din, 1'b1, vecs[0].din);
        in_desc = 1'b0;
        send_one("desc_off", vecs[1].din, 1'b0, vecs[1].dexp);
`endif

        // Mid-stream reset: fill until the first beat is at the output
        @(negedge aclk);
        for (int i = 0; i < 12; i++) begin
            for (int k = 0; k < 16; k++) d[k*W +: W] = 100 + i * 16 + k;
            in_data = d; in_valid = 1'b1;
            @(negedge aclk);
        end
        in_valid = 1'b0;
        chk("prefill_out_valid", out_valid, 1'b1);
        areset = 1'b1;
        #1;
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_in_ready", in_ready, 1'b1);
        @(negedge aclk);
        areset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge aclk);
            seen = seen | out_valid;
        end
        chk("midrst_no_leak", seen, 1'b0);
        send_one("post_rst", vecs[0].din, 1'b1, vecs[0].dexp);

        // Random back-to-back traffic with ~30% downstream stall
        sent = 0; stalled = 1'b0; held_data = '0; held_last = 1'b0;
        for (cyc = 0; cyc < 6000; cyc++) begin
            if (sent == 1000 && exp_q.size() == 0) break;
            @(negedge aclk);
            if (stalled) begin
                chk("stall_valid", out_valid, 1'b1);
                chk("stall_data", out_data, held_data);
                chk("stall_last", out_last, held_last);
            end
            if (sent < 1000) begin
                for (int k = 0; k < 16; k++)
                    d[k*W +: W] = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 7) : $urandom();
                in_data = d; in_last = ($urandom_range(0, 1) != 0); in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            out_ready = ($urandom_range(0, 99) >= 30);
            #1;
            stalled = out_valid && !out_ready;
            held_data = out_data;
            held_last = out_last;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("rand_extra_beat", 1'b1, 1'b0);
                end else begin
                    front = exp_q.pop_front();
                    chk("rand_data", out_data, front);
                    chk("rand_last", out_last, exp_last_q.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(sort16(in_data));
                exp_last_q.push_back(in_last);
                sent++;
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("rand_sent", sent, 1000);
        chk("rand_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
